// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with 3-sample majority vote, optional parity, 1 or 2 stop bits.
// One-word output register with valid/ready handshake; framing and overrun reported as pulses.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | line idle, waiting for a synchronised 1->0 edge
// START    | validating start bit; a high vote is a false start
// DATA     | shifting in DATA_BITS votes, LSB first
// PARITY   | checking the parity bit against the received data
// STOP     | voting stop bit(s); decision taken at last stop vote
// BREAK    | after framing error, waiting for the line to return high

module uart_rx_param #(
   parameter int F          = 8000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 ferr,
   output logic                 overrun,
   output logic                 busy
);

   localparam longint DIV_RAW = (longint'(F) + longint'(BAUD) * OVERSAMPLE / 2)
                                / (longint'(BAUD) * OVERSAMPLE);
   localparam int DIV   = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int S_W   = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [S_W-1:0]   S_A       = S_W'(OVERSAMPLE / 2 - 1);
   localparam logic [S_W-1:0]   S_B       = S_W'(OVERSAMPLE / 2);
   localparam logic [S_W-1:0]   S_V       = S_W'(OVERSAMPLE / 2 + 1);
   localparam logic [S_W-1:0]   S_LAST    = S_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = (STOP_BITS == 2);
   localparam logic             PAR_ODD   = (PARITY == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } state_t;

   state_t state, state_d;

   logic             rx_meta, rx_s, rx_prev;
   logic             fall;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [S_W-1:0]   s_cnt;
   logic [BIT_W-1:0] bit_idx;
   logic             stop_idx;
   logic             stop_bad;
   logic             samp_a, samp_b;
   logic             vote;
   logic             at_vote, at_wrap;
   logic [DATA_BITS-1:0] shreg;
   logic             perr_q;

   logic s_clr, shift_en, perr_en, bit_inc, stop_inc, stop_mark;
   logic frame_good, frame_bad;

   // Synchroniser and edge history preset high so reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign fall = rx_prev & ~rx_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= DIV_W'(DIV - 1);
      end else if (div_cnt == '0) begin
         div_cnt <= DIV_W'(DIV - 1);
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   assign tick    = (div_cnt == '0);
   assign at_vote = tick && (s_cnt == S_V);
   assign at_wrap = tick && (s_cnt == S_LAST);
   assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d    = state;
      s_clr      = 1'b0;
      shift_en   = 1'b0;
      perr_en    = 1'b0;
      bit_inc    = 1'b0;
      stop_inc   = 1'b0;
      stop_mark  = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fall) begin
               state_d = ST_START;
               s_clr   = 1'b1;
            end
         end
         ST_START: begin
            if (at_vote && vote) begin
               state_d = ST_IDLE;
            end else if (at_wrap) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (at_vote) begin
               shift_en = 1'b1;
            end
            if (at_wrap) begin
               if (bit_idx == BIT_LAST) begin
                  state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_inc = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (at_vote) begin
               perr_en = 1'b1;
            end
            if (at_wrap) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // The last stop bit is judged at its vote point; no wait for the bit end.
            if (at_vote) begin
               if (stop_idx == STOP_LAST) begin
                  if (stop_bad || !vote) begin
                     frame_bad = 1'b1;
                     state_d   = ST_BREAK;
                  end else begin
                     frame_good = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end else if (!vote) begin
                  stop_mark = 1'b1;
               end
            end else if (at_wrap) begin
               stop_inc = 1'b1;
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_cnt    <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         stop_bad <= 1'b0;
         samp_a   <= 1'b1;
         samp_b   <= 1'b1;
         shreg    <= '0;
         perr_q   <= 1'b0;
      end else begin
         if (s_clr) begin
            s_cnt <= '0;
         end else if (tick && (state != ST_IDLE) && (state != ST_BREAK)) begin
            s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
         end

         if (s_clr) begin
            bit_idx <= '0;
         end else if (bit_inc) begin
            bit_idx <= bit_idx + 1'b1;
         end

         if (s_clr) begin
            stop_idx <= 1'b0;
         end else if (stop_inc) begin
            stop_idx <= 1'b1;
         end

         if (s_clr) begin
            stop_bad <= 1'b0;
         end else if (stop_mark) begin
            stop_bad <= 1'b1;
         end

         if (tick && (s_cnt == S_A)) begin
            samp_a <= rx_s;
         end
         if (tick && (s_cnt == S_B)) begin
            samp_b <= rx_s;
         end

         if (shift_en) begin
            shreg <= {vote, shreg[DATA_BITS-1:1]};
         end

         if (s_clr) begin
            perr_q <= 1'b0;
         end else if (perr_en) begin
            perr_q <= ((^shreg) ^ vote) != PAR_ODD;
         end
      end
   end

   // Accept and a new delivery in the same cycle replace the word without an overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data  <= '0;
         rx_perr  <= 1'b0;
         rx_valid <= 1'b0;
         ferr     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (frame_good && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_perr  <= perr_q;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         ferr    <= frame_bad;
         overrun <= frame_good && rx_valid && !rx_ready;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three instances (8N1, 8E1, 7O2) at 64 clk per bit.
// Expected words are queued at stimulus time and checked by a monitor on every accept.

module tb_uart_rx_param;

   logic clk;
   logic rst;
   logic rx0, rx1, rx2;
   logic r0, r1, r2;
   logic [7:0] d0, d1;
   logic [6:0] d2;
   logic pe0, pe1, pe2;
   logic v0, v1, v2;
   logic fe0, fe1, fe2;
   logic ov0, ov1, ov2;
   logic b0, b1, b2;

   int checks   = 0;
   int failures = 0;
   int ferr_cnt[3];
   int ovr_cnt[3];
   logic [9:0] q0[$];
   logic [9:0] q1[$];
   logic [9:0] q2[$];

   uart_rx_param #(.F(7372800), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .clk(clk), .rst(rst), .rx(rx0), .rx_data(d0), .rx_perr(pe0), .rx_valid(v0),
      .rx_ready(r0), .ferr(fe0), .overrun(ov0), .busy(b0));

   uart_rx_param #(.F(7372800), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .clk(clk), .rst(rst), .rx(rx1), .rx_data(d1), .rx_perr(pe1), .rx_valid(v1),
      .rx_ready(r1), .ferr(fe1), .overrun(ov1), .busy(b1));

   uart_rx_param #(.F(7372800), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2)) u_7o2 (
      .clk(clk), .rst(rst), .rx(rx2), .rx_data(d2), .rx_perr(pe2), .rx_valid(v2),
      .rx_ready(r2), .ferr(fe2), .overrun(ov2), .busy(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic mon(input int ch, input logic v, input logic r, input logic [8:0] d,
                      input logic pe, input logic fe, input logic ov);
      logic [9:0] e;
      logic       have;
      if (fe) ferr_cnt[ch]++;
      if (ov) ovr_cnt[ch]++;
      if (fe || ov) chk($sformatf("ch%0d_ferr_ovr_exclusive", ch), {31'b0, fe & ov}, 32'd0);
      if (v && r) begin
         have = 1'b0;
         e    = '0;
         case (ch)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            checks++;
            failures++;
            $display("FAIL ch%0d_unexpected_word actual=0x%0h expected=none", ch, {pe, d});
         end else begin
            chk($sformatf("ch%0d_word", ch), {22'b0, pe, d}, {22'b0, e});
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon(0, v0, r0, {1'b0, d0}, pe0, fe0, ov0);
         mon(1, v1, r1, {1'b0, d1}, pe1, fe1, ov1);
         mon(2, v2, r2, {2'b0, d2}, pe2, fe2, ov2);
      end
   end

   task automatic drive(input int ch, input logic val);
      case (ch)
         0: rx0 = val;
         1: rx1 = val;
         default: rx2 = val;
      endcase
   endtask

   function automatic logic [15:0] mk(input logic [8:0] d, input int db, input int np,
                                      input logic pb, input int ns, input logic sv);
      logic [15:0] b;
      b    = '1;
      b[0] = 1'b0;
      for (int i = 0; i < db; i++) b[1+i] = d[i];
      if (np != 0) b[1+db] = pb;
      for (int j = 0; j < ns; j++) b[1+db+np+j] = sv;
      return b;
   endfunction

   // gbit selects a bit that gets a one-sample (4 clk) inversion at its middle.
   task automatic send(input int ch, input logic [15:0] bits, input int n, input int gbit);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #2 drive(ch, bits[i]);
         if (i == gbit) begin
            repeat (32) @(posedge clk);
            #2 drive(ch, ~bits[i]);
            repeat (4) @(posedge clk);
            #2 drive(ch, bits[i]);
            repeat (27) @(posedge clk);
         end else begin
            repeat (63) @(posedge clk);
         end
      end
   endtask

   task automatic frame(input int ch, input logic [8:0] d, input int db, input int np,
                        input logic pb, input int ns, input logic sv, input int gbit);
      send(ch, mk(d, db, np, pb, ns, sv), 1 + db + np + ns, gbit);
   endtask

   task automatic idle(input int ch, input int nbits);
      @(posedge clk); #2 drive(ch, 1'b1);
      repeat (nbits * 64) @(posedge clk);
      #2;
   endtask

   task automatic pulse_ready0();
      @(posedge clk); #2 r0 = 1'b1;
      @(posedge clk); #2 r0 = 1'b0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  f0, o0;
      bit  found;
      rst = 1'b0;
      rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
      r0  = 1'b1; r1  = 1'b1; r2  = 1'b1;
      for (int k = 0; k < 3; k++) begin ferr_cnt[k] = 0; ovr_cnt[k] = 0; end
      repeat (5) @(posedge clk);
      #2;
      chk("reset_rx_valid", {31'b0, v0}, 0);
      chk("reset_rx_data", {24'b0, d0}, 0);
      chk("reset_rx_perr", {31'b0, pe0}, 0);
      chk("reset_busy", {31'b0, b0}, 0);
      chk("reset_ferr", {31'b0, fe0}, 0);
      chk("reset_overrun", {31'b0, ov0}, 0);
      rst = 1'b1;
      repeat (10) @(posedge clk);

      // 8N1 0xA5, consumer always ready
      q0.push_back({1'b0, 9'h0A5});
      frame(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b1, -1);
      idle(0, 2);
      chk("a5_valid_cleared", {31'b0, v0}, 0);
      chk("a5_no_ferr", ferr_cnt[0], 0);
      chk("a5_no_overrun", ovr_cnt[0], 0);

      // 8E1 0x03: parity bit 1 is wrong for even parity, 0 is right
      q1.push_back({1'b1, 9'h003});
      frame(1, 9'h003, 8, 1, 1'b1, 1, 1'b1, -1);
      idle(1, 2);
      q1.push_back({1'b0, 9'h003});
      frame(1, 9'h003, 8, 1, 1'b0, 1, 1'b1, -1);
      idle(1, 2);

      // Framing error followed by a 20-bit break, then a good frame
      f0 = ferr_cnt[0];
      frame(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0, -1);
      drive(0, 1'b0);
      repeat (10 * 64) @(posedge clk);
      #2 chk("break_busy", {31'b0, b0}, 1);
      repeat (10 * 64) @(posedge clk);
      #2 chk("break_one_ferr", ferr_cnt[0] - f0, 1);
      chk("break_no_valid", {31'b0, v0}, 0);
      idle(0, 2);
      q0.push_back({1'b0, 9'h05A});
      frame(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, -1);
      idle(0, 2);
      chk("after_break_one_ferr", ferr_cnt[0] - f0, 1);

      // Overrun: consumer stalled, second word dropped
      r0 = 1'b0;
      o0 = ovr_cnt[0];
      q0.push_back({1'b0, 9'h011});
      frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, -1);
      idle(0, 1);
      frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, -1);
      idle(0, 1);
      chk("ovr_valid_held", {31'b0, v0}, 1);
      chk("ovr_data_held", {24'b0, d0}, 32'h11);
      chk("ovr_one_pulse", ovr_cnt[0] - o0, 1);
      pulse_ready0();
      #1 chk("ovr_accepted", {31'b0, v0}, 0);

      // Accept coinciding with delivery: replace without overrun
      o0 = ovr_cnt[0];
      q0.push_back({1'b0, 9'h011});
      frame(0, 9'h011, 8, 0, 1'b0, 1, 1'b1, -1);
      idle(0, 1);
      q0.push_back({1'b0, 9'h022});
      found = 1'b0;
      fork
         frame(0, 9'h022, 8, 0, 1'b0, 1, 1'b1, -1);
         begin
            for (int k = 0; k < 64 * 12; k++) begin
               @(posedge clk); #2;
               if (u_8n1.frame_good) begin
                  r0    = 1'b1;
                  found = 1'b1;
                  break;
               end
            end
            @(posedge clk); #2 r0 = 1'b0;
         end
      join
      idle(0, 1);
      chk("coincide_found", {31'b0, found}, 1);
      chk("coincide_valid", {31'b0, v0}, 1);
      chk("coincide_data", {24'b0, d0}, 32'h22);
      chk("coincide_no_overrun", ovr_cnt[0] - o0, 0);
      pulse_ready0();
      r0 = 1'b1;

      // Short glitch: false start
      f0 = ferr_cnt[0];
      @(posedge clk); #2 drive(0, 1'b0);
      repeat (8) @(posedge clk);
      #2 chk("glitch_busy", {31'b0, b0}, 1);
      repeat (8) @(posedge clk);
      #2 drive(0, 1'b1);
      repeat (128) @(posedge clk);
      #2 chk("glitch_idle", {31'b0, b0}, 0);
      chk("glitch_no_valid", {31'b0, v0}, 0);
      chk("glitch_no_ferr", ferr_cnt[0] - f0, 0);

      // Single-sample glitch inside data bit 3 of 0xFF
      q0.push_back({1'b0, 9'h0FF});
      frame(0, 9'h0FF, 8, 0, 1'b0, 1, 1'b1, 4);
      idle(0, 2);

      // 7O2: 0x7F, then a frame cut by reset, then 0x01
      q2.push_back({1'b0, 9'h07F});
      frame(2, 9'h07F, 7, 1, 1'b0, 2, 1'b1, -1);
      idle(2, 2);
      send(2, mk(9'h02A, 7, 1, 1'b0, 2, 1'b1), 5, -1);
      chk("mid_frame_busy", {31'b0, b2}, 1);
      @(posedge clk); #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_mid_busy", {31'b0, b2}, 0);
      chk("rst_mid_valid", {31'b0, v2}, 0);
      chk("rst_mid_data", {25'b0, d2}, 0);
      chk("rst_mid_perr", {31'b0, pe2}, 0);
      chk("rst_mid_data_8n1", {24'b0, d0}, 0);
      drive(2, 1'b1);
      rst = 1'b1;
      idle(2, 2);
      q2.push_back({1'b0, 9'h001});
      frame(2, 9'h001, 7, 1, 1'b0, 2, 1'b1, -1);
      idle(2, 2);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      chk("ch1_no_ferr", ferr_cnt[1], 0);
      chk("ch2_no_ferr", ferr_cnt[2], 0);
      chk("ch2_no_overrun", ovr_cnt[2], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
